// File: rtl/stavka_c_driver.sv
// Command-side driver for the 4-bit data/control register: queues target values, issues one load per target
// and verifies the readback. Optional macro ROTATE_ENCODING_EN rotates the load encoding per issued command.
module stavka_c_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    input  logic [3:0]       cmd_data_i,
    output logic             cmd_ready_o,
    output logic [3:0]       drv_data_o,
    output logic [2:0]       drv_control_o,
    input  logic [3:0]       reg_q_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [3:0]       fifo_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       target_q;
    logic [3:0]       drv_data_q, drv_data_d;
    logic [2:0]       drv_ctrl_q, drv_ctrl_d;
    logic [ERR_W-1:0] err_q;

    logic       fifo_empty, fifo_full, push, pop;
    logic [3:0] head;
    logic [3:0] enc_data;
    logic [2:0] enc_ctrl;
    logic       check_fail;

    // The extra pointer bit distinguishes full from empty when the indices coincide.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = cmd_valid_i && !fifo_full;
    assign pop        = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_CHECK));
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];
    assign check_fail = (state_q == S_CHECK) && (reg_q_i != target_q);

`ifdef ROTATE_ENCODING_EN
    logic [1:0] idx_q;

    always_comb begin
        enc_data = head;
        enc_ctrl = 3'b001;
        case (idx_q)
            2'd0: begin
                enc_data = head;
                enc_ctrl = 3'b001;
            end
            2'd1: begin
                enc_data = head - 4'd1;
                enc_ctrl = 3'b101;
            end
            default: begin
                // Odd targets need the +1 after doubling; even targets double cleanly.
                if (head[0]) begin
                    enc_data = (head - 4'd1) >> 1;
                    enc_ctrl = 3'b111;
                end else begin
                    enc_data = head >> 1;
                    enc_ctrl = 3'b011;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
        end else if (pop) begin
            idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end
`else
    assign enc_data = head;
    assign enc_ctrl = 3'b001;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= cmd_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        drv_data_d = drv_data_q;
        drv_ctrl_d = 3'b000;
        case (state_q)
            S_IDLE, S_CHECK: begin
                if (pop) begin
                    state_d    = S_ISSUE;
                    drv_data_d = enc_data;
                    drv_ctrl_d = enc_ctrl;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_CHECK;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= S_IDLE;
            target_q   <= 4'd0;
            drv_data_q <= 4'd0;
            drv_ctrl_q <= 3'b000;
            err_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                target_q <= head;
            end
            state_q    <= state_d;
            drv_data_q <= drv_data_d;
            drv_ctrl_q <= drv_ctrl_d;
            if (check_fail && !(&err_q)) err_q <= err_q + 1'b1;
        end
    end

    assign cmd_ready_o   = !fifo_full;
    assign drv_data_o    = drv_data_q;
    assign drv_control_o = drv_ctrl_q;
    assign busy_o        = (state_q != S_IDLE) || !fifo_empty;
    assign done_o        = (state_q == S_CHECK);
    assign mismatch_o    = check_fail;
    assign err_count_o   = err_q;

endmodule
